// File: rtl/systolic_pe_column_acc_if.sv
// Purpose: bundles the weight, left-side beat and right-side result signals of one PE column.
// Latency: none (wiring only).
// Backpressure: none; every beat is accepted in the cycle it is presented.
interface systolic_pe_column_acc_if #(
    parameter int TIN    = 8,
    parameter int ACC_DW = 32
);
    logic [1:0]               mode;
    logic [TIN*8-1:0]         wt_in;
    logic                     wt_load;
    logic                     wt_swap;
    logic                     in_valid;
    logic                     in_first;
    logic                     in_last;
    logic [TIN*8-1:0]         in_dat;
    logic                     out_valid;
    logic                     out_first;
    logic                     out_last;
    logic [TIN*8-1:0]         out_dat;
    logic                     psum_valid;
    logic signed [ACC_DW-1:0] psum;
    logic                     abort;

    // Upstream / test side: drives weights and beats, observes results.
    modport master (
        output mode, wt_in, wt_load, wt_swap, in_valid, in_first, in_last, in_dat,
        input  out_valid, out_first, out_last, out_dat, psum_valid, psum, abort
    );

    // PE column side.
    modport slave (
        input  mode, wt_in, wt_load, wt_swap, in_valid, in_first, in_last, in_dat,
        output out_valid, out_first, out_last, out_dat, psum_valid, psum, abort
    );
endinterface

// File: rtl/systolic_pe_column_acc.sv
// Purpose: one systolic PE column; per-beat multi-precision dot product accumulated over first..last.
// Latency: beat forwarded right after 1 cycle; psum_valid 2 cycles after the last beat is sampled.
// Backpressure: none; a beat can be accepted every cycle, results may run back to back.
module systolic_pe_column_acc #(
    parameter int TIN    = 8,
    parameter int ACC_DW = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    systolic_pe_column_acc_if.slave     bus
);
    localparam int DW = TIN * 8;
    // A full-precision lane product fits 16 signed bits; summing TIN lanes adds log2(TIN) bits.
    localparam int SW = 17 + $clog2(TIN);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [DW-1:0]           wt_shadow;
    logic [DW-1:0]           wt_active;
    logic [1:0]              mode_lat;
    logic [1:0]              mode_eff;
    logic [1:0]              mode_in;
    logic signed [15:0]      lane_p;
    logic signed [SW-1:0]    beat_sum;
    logic signed [SW-1:0]    s1_sum;
    logic signed [ACC_DW-1:0] s_ext;
    logic signed [ACC_DW-1:0] acc;
    logic signed [ACC_DW-1:0] acc_nxt;
    logic [0:0]              state;

    // Signed dot product of the sub-words of one data byte against one weight byte.
    function automatic logic signed [15:0] lane_dot(input logic [7:0] d, input logic [7:0] w,
                                                    input logic [1:0] m);
        logic signed [15:0] ds;
        logic signed [15:0] ws;
        logic signed [15:0] sum;
        sum = '0;
        case (m)
            2'd1: begin
                for (int k = 0; k < 2; k++) begin
                    ds  = {{12{d[4*k+3]}}, d[4*k +: 4]};
                    ws  = {{12{w[4*k+3]}}, w[4*k +: 4]};
                    sum = sum + ds * ws;
                end
            end
            2'd2: begin
                for (int k = 0; k < 4; k++) begin
                    ds  = {{14{d[2*k+1]}}, d[2*k +: 2]};
                    ws  = {{14{w[2*k+1]}}, w[2*k +: 2]};
                    sum = sum + ds * ws;
                end
            end
            default: begin
                ds  = {{8{d[7]}}, d};
                ws  = {{8{w[7]}}, w};
                sum = ds * ws;
            end
        endcase
        return sum;
    endfunction

    // Double-buffered weights; a coincident load and swap moves the old shadow into active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_shadow <= '0;
            wt_active <= '0;
        end else begin
            if (bus.wt_load) wt_shadow <= bus.wt_in;
            if (bus.wt_swap) wt_active <= wt_shadow;
        end
    end

    // Precision for this beat: a first beat uses the live mode, later beats the mode latched at first.
    always_comb begin
        mode_in  = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
        mode_eff = (bus.in_valid && bus.in_first) ? mode_in : mode_lat;
    end

    // Beat sum across all lanes using the weights active in the sampling cycle.
    always_comb begin
        beat_sum = '0;
        lane_p   = '0;
        for (int i = 0; i < TIN; i++) begin
            lane_p   = lane_dot(bus.in_dat[8*i +: 8], wt_active[8*i +: 8], mode_eff);
            beat_sum = beat_sum + {{(SW-16){lane_p[15]}}, lane_p};
        end
    end

    // Stage 1: forward the beat unconditionally and register its sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_dat   <= '0;
            s1_sum        <= '0;
            mode_lat      <= 2'd0;
        end else begin
            bus.out_valid <= bus.in_valid;
            bus.out_first <= bus.in_first;
            bus.out_last  <= bus.in_last;
            bus.out_dat   <= bus.in_dat;
            s1_sum        <= beat_sum;
            if (bus.in_valid && bus.in_first) mode_lat <= mode_in;
        end
    end

    // A first beat restarts the accumulation; otherwise the beat adds on (wrapping).
    always_comb begin
        s_ext   = {{(ACC_DW-SW){s1_sum[SW-1]}}, s1_sum};
        acc_nxt = bus.out_first ? s_ext : acc + s_ext;
    end

    // Stage 2: IDLE/ACCUM accumulator acting on the stage-1 beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            acc            <= '0;
            bus.psum       <= '0;
            bus.psum_valid <= 1'b0;
            bus.abort      <= 1'b0;
        end else begin
            bus.psum_valid <= 1'b0;
            bus.abort      <= 1'b0;
            if (bus.out_valid) begin
                // Beats arriving in IDLE without first belong to no result and are dropped.
                if (bus.out_first || state == ST_ACCUM) acc <= acc_nxt;
                if (bus.out_first && state == ST_ACCUM) bus.abort <= 1'b1;
                if (bus.out_last && (bus.out_first || state == ST_ACCUM)) begin
                    bus.psum       <= acc_nxt;
                    bus.psum_valid <= 1'b1;
                    state          <= ST_IDLE;
                end else if (bus.out_first) begin
                    state <= ST_ACCUM;
                end
            end
        end
    end
endmodule
